write_back_arbiter: RTL and testbench
=====================================

# write_back_arbiter

Shares the single register-file write port between the in-order pipeline write-back (output of the write-back stage: MemToReg-selected `write_data` plus destination register) and the multi-cycle multiply/divide unit (MDU). The pipeline has priority; MDU results that cannot be written immediately are held in a small pending FIFO and drained into idle write-port cycles. A destination scoreboard is exported to the hazard unit, and an optional starvation guard can stall write-back to force a drain.

## Interface
- `DEPTH`, 4, pending FIFO entries; power of 2, range 2..8
- `STARVE_LIMIT`, 8, consecutive blocked cycles before a forced drain; range 1..255
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `wb_valid`  in  1  pipeline write-back requests a write this cycle (RegWrite)
- `wb_reg_addr`  in  5  pipeline destination register
- `wb_data`  in  32  pipeline write data
- `mdu_valid`  in  1  MDU result available
- `mdu_ready`  out  1  arbiter accepts MDU result; `fifo_count < DEPTH`
- `mdu_reg_addr`  in  5  MDU destination register
- `mdu_data`  in  32  MDU result
- `rf_we`  out  1  register-file write enable (registered)
- `rf_addr`  out  5  register-file write address (registered)
- `rf_wdata`  out  32  register-file write data (registered)
- `busy_mask`  out  32  bit r set while any FIFO entry targets register r
- `fifo_count`  out  $clog2(DEPTH+1)  pending entries
- `stall_wb`  out  1  request to hold the write-back instruction for one cycle

## Operation
- MDU transfer occurs on a rising edge with `mdu_valid && mdu_ready`.
- Writes to `$0` are discarded. A pipeline write to 0 does not claim the port. An accepted MDU result to 0 is consumed and neither enqueued nor written.
- Port selection per cycle, in priority order:
  1. FORCE state: FIFO head.
  2. `wb_valid && wb_reg_addr != 0`: pipeline.
  3. FIFO non-empty: FIFO head (pop).
  4. Accepted MDU result: bypasses the FIFO and writes directly.
  5. Otherwise `rf_we = 0` next cycle; `rf_addr`/`rf_wdata` hold their values.
- An accepted MDU result that does not win the port is enqueued at the tail.
- Enqueue and pop in the same cycle are legal; the count is unchanged.
- FIFO order is strict; the head is always the oldest entry.
- `busy_mask` is the OR of one-hot decodes of the valid entries' destinations, from registered state.
- The arbiter does not resolve WAW/RAW hazards. The hazard unit must stall any instruction that reads or writes a register whose `busy_mask` bit is set.
- Starvation FSM (`WB_ARB_STARVE_GUARD_EN` only):
  - States: NORMAL and FORCE.
  - `starve_cnt` increments each cycle the FIFO is non-empty and the pipeline takes the port.
  - `starve_cnt` clears on any pop or whenever the FIFO is empty.
  - NORMAL -> FORCE when `starve_cnt` reaches `STARVE_LIMIT`.
  - FORCE lasts exactly one cycle: `stall_wb = 1`, head pops, `wb_valid` is ignored (the pipeline re-presents the same write next cycle).
  - FORCE -> NORMAL, `starve_cnt = 0`.

## Timing
- Reset values:
  - `rf_we = 0`, `rf_addr = 0`, `rf_wdata = 0`.
  - `fifo_count = 0`, `busy_mask = 0`, `stall_wb = 0`, `mdu_ready = 1`.
  - State NORMAL, `starve_cnt = 0`.
- Reset mid-operation discards all pending entries immediately (asynchronous).
- Latency: the selected write appears on `rf_*` one cycle after the selecting edge. MDU bypass latency is 1; a queued entry needs 1 + (cycles waiting at head).
- `mdu_ready`, `busy_mask`, `fifo_count` and `stall_wb` are functions of registered state only; there is no combinational path from inputs.
- Full (`fifo_count == DEPTH`): `mdu_ready = 0`. It returns to 1 the cycle after a pop.
- Empty: a pop is impossible; an MDU result takes the port directly if the pipeline is idle.
- FIFO pointers wrap modulo DEPTH.

## Configuration
- `WB_ARB_STARVE_GUARD_EN` defined: the starvation counter and NORMAL/FORCE FSM are built as above.
- Not defined: the pipeline has absolute priority, `stall_wb` is tied to 0, no counter is built, and `STARVE_LIMIT` is unused.

## Test plan
- Reset, then pipeline-only: `wb_valid = 1`, addr 5, data 111 -> next cycle `rf_we = 1`, `rf_addr = 5`, `rf_wdata = 111`. Data 222 with addr 0 -> `rf_we = 0`.
- MDU bypass: pipeline idle, MDU addr 9, data 0xDEAD accepted -> next cycle `rf_addr = 9`, `rf_wdata = 0xDEAD`, `fifo_count = 0`.
- Collision: pipeline addr 3 and MDU addr 7 in the same cycle -> reg 3 written first; `busy_mask = 0x80`, `fifo_count = 1`. When the pipeline goes idle, reg 7 is written and `busy_mask = 0`.
- Full: pipeline busy continuously, 4 MDU results to regs 10..13 -> `mdu_ready = 0` at `fifo_count = 4`. With the guard disabled, regs 10..13 drain in order once the pipeline goes idle.
- Starvation (guard enabled, `STARVE_LIMIT = 8`): one pending entry and `wb_valid` held high -> 8 pipeline writes, then one cycle with `stall_wb = 1` and the head written, then the held pipeline write is written.
- Reset mid-operation: assert `rst_n = 0` with 3 entries pending -> `fifo_count = 0`, `busy_mask = 0`, `rf_we = 0` immediately; no stale write follows release.

Source files
------------

// File: rtl/write_back_arbiter.sv
// Shares the register-file write port between pipeline write-back and the MDU.
// Optional starvation guard is built when WB_ARB_STARVE_GUARD_EN is defined.
module write_back_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wb_valid,
   input  logic [4:0]                 wb_reg_addr,
   input  logic [31:0]                wb_data,
   input  logic                       mdu_valid,
   output logic                       mdu_ready,
   input  logic [4:0]                 mdu_reg_addr,
   input  logic [31:0]                mdu_data,
   output logic                       rf_we,
   output logic [4:0]                 rf_addr,
   output logic [31:0]                rf_wdata,
   output logic [31:0]                busy_mask,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       stall_wb
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [4:0]    q_addr [DEPTH];
   logic [31:0]   q_data [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [PW-1:0] off;

   logic force_sel;
   logic empty;
   logic accept;
   logic mdu_live;
   logic wb_live;
   logic sel_wb;
   logic sel_pop;
   logic sel_byp;
   logic push;

   assign empty      = (count == '0);
   assign mdu_ready  = (count < CW'(DEPTH));
   assign fifo_count = count;
   assign accept     = mdu_valid && mdu_ready;
   assign mdu_live   = accept && (mdu_reg_addr != 5'd0);
   assign wb_live    = wb_valid && (wb_reg_addr != 5'd0);

   always_comb begin
      sel_wb  = 1'b0;
      sel_pop = 1'b0;
      sel_byp = 1'b0;
      if (force_sel)
         sel_pop = !empty;
      else if (wb_live)
         sel_wb = 1'b1;
      else if (!empty)
         sel_pop = 1'b1;
      else
         sel_byp = mdu_live;
   end

   assign push = mdu_live && !sel_byp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= tail + 1'b1;
         if (sel_pop)
            head <= head + 1'b1;
         count <= count + CW'(push) - CW'(sel_pop);
      end
   end

   // Payload storage needs no reset: only entries inside head..count are read.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[tail] <= mdu_reg_addr;
         q_data[tail] <= mdu_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_addr  <= 5'd0;
         rf_wdata <= 32'd0;
      end else begin
         rf_we <= sel_wb | sel_pop | sel_byp;
         unique case (1'b1)
            sel_wb: begin
               rf_addr  <= wb_reg_addr;
               rf_wdata <= wb_data;
            end
            sel_pop: begin
               rf_addr  <= q_addr[head];
               rf_wdata <= q_data[head];
            end
            sel_byp: begin
               rf_addr  <= mdu_reg_addr;
               rf_wdata <= mdu_data;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy_mask = '0;
      off       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - head;
         if (CW'(off) < count)
            busy_mask[q_addr[i]] = 1'b1;
      end
   end

`ifdef WB_ARB_STARVE_GUARD_EN
   typedef enum logic {ST_NORMAL, ST_FORCE} arb_state_t;

   arb_state_t state;
   arb_state_t state_nxt;
   logic [7:0] starve_cnt;
   logic [7:0] starve_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_NORMAL;
         starve_cnt <= 8'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // Forcing on the edge the limit is reached caps the pipeline at LIMIT wins.
   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      unique case (state)
         ST_FORCE: begin
            state_nxt  = ST_NORMAL;
            starve_nxt = 8'd0;
         end
         default: begin
            if (!empty && sel_wb)
               starve_nxt = starve_cnt + 8'd1;
            else
               starve_nxt = 8'd0;
            if (starve_nxt >= 8'(STARVE_LIMIT))
               state_nxt = ST_FORCE;
         end
      endcase
   end

   always_comb begin
      force_sel = (state == ST_FORCE);
      stall_wb  = force_sel;
   end
`else
   localparam int unused_limit = STARVE_LIMIT;

   assign force_sel = 1'b0;
   assign stall_wb  = 1'b0;
`endif

endmodule

// File: tb/tb_write_back_arbiter.sv
// Randomized + directed bench for write_back_arbiter against a queue model.
// Follows the DUT build: define WB_ARB_STARVE_GUARD_EN for both or neither.
module tb_write_back_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_reg_addr = '0;
   logic [31:0] wb_data = '0;
   logic        mdu_valid = 1'b0;
   logic        mdu_ready;
   logic [4:0]  mdu_reg_addr = '0;
   logic [31:0] mdu_data = '0;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic [31:0] busy_mask;
   logic [2:0]  fifo_count;
   logic        stall_wb;

   always #5 clk = ~clk;

   write_back_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_reg_addr(wb_reg_addr), .wb_data(wb_data),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
      .mdu_reg_addr(mdu_reg_addr), .mdu_data(mdu_data),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
      .busy_mask(busy_mask), .fifo_count(fifo_count), .stall_wb(stall_wb)
   );

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   bit          m_frc;
   int          m_starve;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_frc = 1'b0;
      m_starve = 0;
   endtask

   task automatic model_step();
      bit ne, acc, pop, take, byp;
      ne   = q.size() > 0;
      acc  = mdu_valid && (q.size() < DEPTH);
      pop  = 1'b0;
      take = 1'b0;
      byp  = 1'b0;
      if (m_frc) pop = ne;
      else if (wb_valid && wb_reg_addr != 0) take = 1'b1;
      else if (ne) pop = 1'b1;
      else if (acc && mdu_reg_addr != 0) byp = 1'b1;
      m_we = pop | take | byp;
      if (pop) begin
         m_addr = q[0].a;
         m_data = q[0].d;
      end else if (take) begin
         m_addr = wb_reg_addr;
         m_data = wb_data;
      end else if (byp) begin
         m_addr = mdu_reg_addr;
         m_data = mdu_data;
      end
`ifdef WB_ARB_STARVE_GUARD_EN
      if (m_frc) begin
         m_frc = 1'b0;
         m_starve = 0;
      end else begin
         m_starve = (ne && take) ? m_starve + 1 : 0;
         if (m_starve >= LIMIT) m_frc = 1'b1;
      end
`endif
      if (pop) void'(q.pop_front());
      if (acc && mdu_reg_addr != 0 && !byp)
         q.push_back('{mdu_reg_addr, mdu_data});
   endtask

   task automatic check_all();
      logic [31:0] bm;
      bm = '0;
      foreach (q[i]) bm[q[i].a] = 1'b1;
      check("rf_we", rf_we, m_we);
      check("rf_addr", rf_addr, m_addr);
      check("rf_wdata", rf_wdata, m_data);
      check("busy_mask", busy_mask, bm);
      check("fifo_count", fifo_count, q.size());
      check("mdu_ready", mdu_ready, q.size() < DEPTH);
      check("stall_wb", stall_wb, m_frc);
   endtask

   task automatic cyc(bit wv, logic [4:0] wa, logic [31:0] wd,
                      bit mv, logic [4:0] ma, logic [31:0] md);
      wb_valid = wv;
      wb_reg_addr = wa;
      wb_data = wd;
      mdu_valid = mv;
      mdu_reg_addr = ma;
      mdu_data = md;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   int prob [6] = '{30, 95, 60, 100, 10, 80};

   initial begin
      model_reset();
      #12;
      check("rst_rf_we", rf_we, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", mdu_ready, 1);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      cyc(1, 5, 111, 0, 0, 0);
      check("wb_addr5", rf_addr, 5);
      check("wb_data111", rf_wdata, 111);
      cyc(1, 0, 222, 0, 0, 0);
      check("wb_x0_we", rf_we, 0);

      cyc(0, 0, 0, 1, 9, 32'hDEAD);
      check("byp_addr", rf_addr, 9);
      check("byp_data", rf_wdata, 32'hDEAD);
      check("byp_count", fifo_count, 0);

      cyc(1, 3, 33, 1, 7, 77);
      check("col_addr", rf_addr, 3);
      check("col_busy", busy_mask, 32'h80);
      check("col_count", fifo_count, 1);
      cyc(0, 0, 0, 0, 0, 0);
      check("col_drain", rf_addr, 7);
      check("col_busy0", busy_mask, 0);

      for (int i = 0; i < 4; i++)
         cyc(1, 5'(1 + i), 32'(i), 1, 5'(10 + i), 32'(100 + i));
      check("full_cnt", fifo_count, 4);
      check("full_rdy", mdu_ready, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         check("full_order", rf_addr, 10 + i);
         if (i == 0) check("full_rdy_back", mdu_ready, 1);
      end

`ifdef WB_ARB_STARVE_GUARD_EN
      cyc(1, 2, 500, 1, 20, 2020);
      for (int i = 0; i < LIMIT; i++) begin
         cyc(1, 2, 32'(600 + i), 0, 0, 0);
         check("stv_wb", rf_addr, 2);
      end
      check("stv_stall", stall_wb, 1);
      cyc(1, 2, 700, 0, 0, 0);
      check("stv_head", rf_addr, 20);
      check("stv_stall0", stall_wb, 0);
      cyc(1, 2, 700, 0, 0, 0);
      check("stv_held", rf_wdata, 700);
`endif

      for (int i = 0; i < 3; i++)
         cyc(1, 5'(4 + i), 32'(i), 1, 5'(20 + i), 32'(i));
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("mid_count", fifo_count, 0);
      check("mid_busy", busy_mask, 0);
      check("mid_we", rf_we, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);
      check("mid_nostale", rf_we, 0);

      for (int i = 0; i < 600; i++) begin
         logic [4:0] wa;
         wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         cyc($urandom_range(0, 99) < prob[i / 100], wa, $urandom,
             $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
